// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared eco32 ROM arbiter state encodings, port ids and defaults.
package rom_arbiter_pkg;
    localparam int WDOG_DEFAULT = 255;
    typedef enum logic [1:0] {IDLE, HIT, FETCH, DONE} arb_state_t;
    typedef enum logic {PORT_INST, PORT_DATA} port_t;
endpackage

// File: rtl/rom_arbiter.sv
// rom_arbiter: arbitrates instruction/data line requests onto one ROM port,
// serving repeats from a single-line buffer and bounding each fetch with a watchdog.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int WDOG_CYCLES = WDOG_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inst_stb,
    input  logic [23:0]  inst_addr,
    output logic [127:0] inst_dout,
    output logic         inst_ack,
    output logic         inst_timeout,
    input  logic         data_stb,
    input  logic [23:0]  data_addr,
    output logic [127:0] data_dout,
    output logic         data_ack,
    output logic         data_timeout,
    input  logic         inv,
    output logic         rom_stb,
    output logic [23:0]  rom_addr,
    input  logic [127:0] rom_din,
    input  logic         rom_ack,
    input  logic         rom_timeout
);
    arb_state_t   state, state_d;
    port_t        gnt, last_grant, sel_port;
    logic [23:0]  addr_q, sel_addr, buf_tag;
    logic [127:0] buf_data;
    logic [7:0]   wdog;
    logic         buf_valid, mask_vld, to_q;
    logic         inst_ok, data_ok, any_req, is_hit, fetch_end, serve, respond;

    // The port answered last cycle may still show its old strobe, so it sits out one IDLE cycle.
    always_comb begin
        inst_ok   = inst_stb && !(mask_vld && gnt == PORT_INST);
        data_ok   = data_stb && !(mask_vld && gnt == PORT_DATA);
        any_req   = inst_ok || data_ok;
        sel_port  = (inst_ok && data_ok) ? (last_grant == PORT_INST ? PORT_DATA : PORT_INST)
                                         : (data_ok ? PORT_DATA : PORT_INST);
        sel_addr  = sel_port == PORT_DATA ? data_addr : inst_addr;
        is_hit    = buf_valid && sel_addr == buf_tag && !inv;
        fetch_end = rom_ack || rom_timeout || wdog <= 8'd1;
        serve     = state == HIT || state == DONE;
        respond   = state == HIT || (state == DONE && !to_q);
        state_d   = state;
        case (state)
            IDLE:    state_d = !any_req ? IDLE : (is_hit ? HIT : FETCH);
            FETCH:   state_d = fetch_end ? DONE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inst_ack     = respond && gnt == PORT_INST;
        data_ack     = respond && gnt == PORT_DATA;
        inst_timeout = state == DONE && to_q && gnt == PORT_INST;
        data_timeout = state == DONE && to_q && gnt == PORT_DATA;
        rom_stb      = state == FETCH;
        rom_addr     = addr_q;
        inst_dout    = buf_data;
        data_dout    = buf_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            buf_valid  <= 1'b0;
            last_grant <= PORT_INST;
            wdog       <= 8'd0;
            mask_vld   <= 1'b0;
        end else begin
            state      <= state_d;
            mask_vld   <= serve;
            last_grant <= serve ? gnt : last_grant;
            wdog       <= state_d != FETCH ? 8'd0 : (state == IDLE ? 8'(WDOG_CYCLES) : wdog - 8'd1);
            buf_valid  <= !inv && (buf_valid || (state == FETCH && rom_ack));
        end
    end

    // Grant, address and fill data need no reset: they are only observed behind state.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) begin
            gnt    <= sel_port;
            addr_q <= sel_addr;
        end
        if (state == FETCH)
            to_q <= !rom_ack;
        if (state == FETCH && rom_ack) begin
            buf_data <= rom_din;
            buf_tag  <= addr_q;
        end
    end
endmodule
